// File: rtl/uart_tx_pkg.sv
// Shared state encoding, line-level constants and parity helper for the UART TX framer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Even parity is the plain XOR of the payload; odd parity is its complement.
    function automatic logic parity_bit(input logic xor_red, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first payload shifter with a bit counter that flags the last payload bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift,
    input  logic                  cnt_clr,
    input  logic                  cnt_en,
    output logic                  bit_out,
    output logic                  done
);

    logic [DATA_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]      cnt;

    // bit_out is the next bit to place on the line; shifting consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data;
        end else if (shift) begin
            sreg <= sreg >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_en && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_out = sreg[0];
    assign done    = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, one stop bit.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  READY,
    output logic                  BUSY,
    output logic                  TX_OUT,
    output logic [2:0]            STATE_DBG
);

    // Handshake: a byte is taken on a rising edge where DATA_VALID and READY are both
    // high; otherwise the upstream holds P_DATA until READY returns.
    state_t state_q, state_d;
    logic   accept;
    logic   par_en_q, par_bit_q;
    logic   tx_d;
    logic   ser_bit, ser_done;
    logic   in_data;

    assign READY     = (state_q == S_IDLE) || (state_q == S_STOP);
    assign BUSY      = (state_q != S_IDLE);
    assign STATE_DBG = state_q;
    assign accept    = DATA_VALID && READY;
    assign in_data   = (state_q == S_DATA);

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk     (CLK),
        .rst     (RST),
        .load    (accept),
        .data    (P_DATA),
        .shift   ((state_q == S_START) || (in_data && !ser_done)),
        .cnt_clr (state_q == S_START),
        .cnt_en  (in_data),
        .bit_out (ser_bit),
        .done    (ser_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_START;
            S_START:  state_d = S_DATA;
            S_DATA:   if (ser_done) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = accept ? S_START : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The line level is chosen from the state being entered so TX_OUT is a plain flop.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            S_IDLE:   tx_d = IDLE_LEVEL;
            S_START:  tx_d = START_BIT;
            S_DATA:   tx_d = ser_bit;
            S_PARITY: tx_d = par_bit_q;
            S_STOP:   tx_d = IDLE_LEVEL;
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    // Parity is fixed at accept time from the byte being latched into the shifter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            TX_OUT    <= IDLE_LEVEL;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            if (accept) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= parity_bit(^P_DATA, PAR_TYP);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized frame checks for uart_tx_frame against a bit-list frame model.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       ready, busy, tx_out;
    logic [2:0] state_dbg;

    int passed = 0;
    int total  = 0;

    logic [0:0] exp_q[$];
    logic [0:0] stop_q[$];

    uart_tx_frame #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .READY      (ready),
        .BUSY       (busy),
        .TX_OUT     (tx_out),
        .STATE_DBG  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, got, exp);
    endtask

    // Reference frame: start 0, payload LSB first, parity from the count of ones, stop 1.
    task automatic model_push(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        stop_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(1'((d >> i) & 8'd1));
            stop_q.push_back(1'b0);
        end
        if (pe) begin
            exp_q.push_back(1'(($countones(d) % 2) ^ int'(pt)));
            stop_q.push_back(1'b0);
        end
        exp_q.push_back(1'b1);
        stop_q.push_back(1'b1);
    endtask

    task automatic check_cycle(input string tag);
        logic b, s;
        b = exp_q.pop_front();
        s = stop_q.pop_front();
        chk({tag, "_tx"}, tx_out, b);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_ready"}, ready, s);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tx"}, tx_out, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_ready"}, ready, 1'b1);
    endtask

    // Called at a negedge; present one byte for one cycle and check its whole frame.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt);
        p_data = d;
        par_en = pe;
        par_typ = pt;
        data_valid = 1'b1;
        model_push(d, pe, pt);
        @(negedge clk);
        data_valid = 1'b0;
        while (exp_q.size() > 0) begin
            check_cycle(tag);
            @(negedge clk);
        end
        check_idle(tag);
    endtask

    initial begin
        int i;
        // reset state
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        send_frame("even_a5", 8'hA5, 1'b1, 1'b0);
        send_frame("odd_04", 8'h04, 1'b1, 1'b1);
        send_frame("even_dd", 8'hDD, 1'b1, 1'b0);
        send_frame("nopar_aa", 8'hAA, 1'b0, 1'b0);

        // back-to-back with DATA_VALID held; second byte presented during the stop bit
        p_data = 8'hAA;
        par_en = 1'b1;
        par_typ = 1'b0;
        data_valid = 1'b1;
        model_push(8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        i = 0;
        while (exp_q.size() > 0) begin
            check_cycle("b2b");
            if (i == 10) begin
                p_data = 8'h55;
                model_push(8'h55, 1'b1, 1'b0);
            end
            if (i == 11) data_valid = 1'b0;
            i++;
            @(negedge clk);
        end
        chk("b2b_len", 1'(i == 22), 1'b1);
        check_idle("b2b");

        // configuration changed mid-frame must not disturb the frame in flight
        p_data = 8'h3C;
        par_en = 1'b1;
        par_typ = 1'b0;
        data_valid = 1'b1;
        model_push(8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            check_cycle("latch");
            if (i == 4) begin
                p_data = 8'hF1;
                par_typ = 1'b1;
            end
            i++;
            @(negedge clk);
        end
        check_idle("latch");
        send_frame("latch_new", 8'hF1, 1'b1, 1'b1);

        // reset during data bit 3
        p_data = 8'h96;
        par_en = 1'b1;
        par_typ = 1'b1;
        data_valid = 1'b1;
        model_push(8'h96, 1'b1, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_cycle("pre_rst");
            if (c < 4) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        exp_q.delete();
        stop_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle("after_rst");
        end

        // randomized frames with random idle gaps
        for (int n = 0; n < 25; n++) begin
            send_frame("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clk);
                check_idle("rand_gap");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
